// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and runs a fetch / wait-response / execute / update loop per instruction.
// Latency: at least 4 cycles per instruction (handshake, response, exec_done, update); new pc appears in the next FETCH.
// Backpressure: FETCH holds req_valid/req_addr until req_ready; WAIT_RESP and EXEC stall until resp_valid / exec_done.
// Optional feature: define PC_SEQ_MISALIGN_TRAP_EN to trap on targets with next_pc[1:0] != 0 instead of masking them.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RST_VALUE = 32'h80000000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             req_valid,
  output logic [WIDTH-1:0] req_addr,
  input  logic             req_ready,
  input  logic             resp_valid,
  input  logic [31:0]      resp_inst,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             exec_done,
  input  logic [1:0]       jump_type,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] rs1Data,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instret,
  output logic             trap,
  output logic [WIDTH-1:0] trap_addr
);

  localparam logic [1:0] JT_SEQ  = 2'b00;
  localparam logic [1:0] JT_JAL  = 2'b01;
  localparam logic [1:0] JT_JALR = 2'b10;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {FETCH, WAIT_RESP, EXEC, UPDATE, TRAP} state_t;
`else
  typedef enum logic [1:0] {FETCH, WAIT_RESP, EXEC, UPDATE} state_t;
`endif

  state_t           state, state_next;
  logic [1:0]       jt_q;
  logic             bt_q;
  logic [WIDTH-1:0] rs1_q, imm_q;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic             commit;

  assign req_addr   = pc;
  assign inst_valid = (state == EXEC);

  // Raw jump target from the feedback captured at exec_done.
  always_comb begin
    target = pc + WIDTH'(4);
    case (jt_q)
      JT_SEQ:  target = pc + WIDTH'(4);
      JT_JAL:  target = pc + imm_q;
      JT_JALR: target = (rs1_q + imm_q) & ~WIDTH'(1);
      default: target = bt_q ? (pc + imm_q) : (pc + WIDTH'(4));
    endcase
  end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic misalign;
  logic trap_q;
  logic [WIDTH-1:0] trap_addr_q;

  assign misalign  = (target[1:0] != 2'b00);
  assign next_pc   = target;
  assign commit    = (state == UPDATE) && !misalign;
  assign trap      = trap_q;
  assign trap_addr = trap_addr_q;

  // Sticky trap record: set when an update would land on a misaligned target, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else if (state == UPDATE && misalign) begin
      trap_q      <= 1'b1;
      trap_addr_q <= target;
    end
  end
`else
  // Without trapping, the low two target bits are simply dropped.
  assign next_pc   = target & ~WIDTH'(3);
  assign commit    = (state == UPDATE);
  assign trap      = 1'b0;
  assign trap_addr = '0;
`endif

  // Next-state decode; req_valid is a register so it can be low in the cycle following reset.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:     if (req_valid && req_ready) state_next = WAIT_RESP;
      WAIT_RESP: if (resp_valid) state_next = EXEC;
      EXEC:      if (exec_done) state_next = UPDATE;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      UPDATE:    state_next = misalign ? TRAP : FETCH;
      TRAP:      state_next = TRAP;
`else
      UPDATE:    state_next = FETCH;
`endif
      default:   state_next = FETCH;
    endcase
  end

  // State register plus registered request-valid derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      req_valid <= 1'b0;
    end else begin
      state     <= state_next;
      req_valid <= (state_next == FETCH);
    end
  end

  // Datapath: latch the instruction, capture execute feedback, commit pc/instret in UPDATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst    <= '0;
      pc      <= RST_VALUE;
      instret <= '0;
      jt_q    <= JT_SEQ;
      bt_q    <= 1'b0;
      rs1_q   <= '0;
      imm_q   <= '0;
    end else begin
      if (state == WAIT_RESP && resp_valid) begin
        inst <= resp_inst;
      end
      if (state == EXEC && exec_done) begin
        jt_q  <= jump_type;
        bt_q  <= branch_taken;
        rs1_q <= rs1Data;
        imm_q <= imm;
      end
      if (commit) begin
        pc      <= next_pc;
        instret <= instret + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instruction stream.
// Expected PCs come from a plain-arithmetic model of the jump rules.
// All handshake waits are bounded; an expired bound counts as a failure.
module tb_pc_sequencer;

  localparam logic [31:0] RSTV = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_inst = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exec_done = 1'b0;
  logic [1:0]  jump_type = '0;
  logic        branch_taken = 1'b0;
  logic [31:0] rs1Data = '0;
  logic [31:0] imm = '0;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        trap;
  logic [31:0] trap_addr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .inst(inst), .inst_valid(inst_valid),
    .exec_done(exec_done), .jump_type(jump_type), .branch_taken(branch_taken),
    .rs1Data(rs1Data), .imm(imm),
    .pc(pc), .instret(instret), .trap(trap), .trap_addr(trap_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: architectural next-PC rules.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] jt,
                                             input logic bt, input logic [31:0] r, input logic [31:0] i);
    logic [31:0] t;
    case (jt)
      2'd0:    t = p + 32'd4;
      2'd1:    t = p + i;
      2'd2:    t = (r + i) & 32'hFFFF_FFFE;
      default: t = bt ? p + i : p + 32'd4;
    endcase
`ifndef PC_SEQ_MISALIGN_TRAP_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; exec_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one full instruction through the loop and reports what it observed.
  task automatic do_instr(input int rdy_dly, input int rsp_dly, input int ex_dly, input bit junk,
                          input logic [1:0] jt, input logic bt, input logic [31:0] rs1v,
                          input logic [31:0] immv, input logic [31:0] word,
                          output logic [31:0] addr_seen, output logic [31:0] inst_seen,
                          output logic iv_exec, output logic iv_upd, output logic stall_ok,
                          output logic ok, output int hs_cyc);
    int n;
    ok = 1'b1; stall_ok = 1'b1; addr_seen = 'x; inst_seen = 'x;
    iv_exec = 1'b0; iv_upd = 1'b1; hs_cyc = 0;
    n = 0;
    while (req_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (req_valid !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    addr_seen = req_addr;
    for (int k = 0; k < rdy_dly; k++) begin
      req_ready = 1'b0;
      resp_valid = junk && (k == 1);
      resp_inst = ~word;
      @(negedge clk);
      resp_valid = 1'b0;
      if (req_valid !== 1'b1 || req_addr !== addr_seen) stall_ok = 1'b0;
    end
    hs_cyc = cyc;
    req_ready = 1'b1; resp_valid = junk; resp_inst = ~word;
    @(negedge clk);
    req_ready = 1'b0; resp_valid = 1'b0;
    if (req_valid !== 1'b0) ok = 1'b0;
    for (int k = 0; k < rsp_dly; k++) @(negedge clk);
    resp_valid = 1'b1; resp_inst = word;
    @(negedge clk);
    resp_valid = 1'b0; resp_inst = $urandom;
    iv_exec = inst_valid;
    inst_seen = inst;
    for (int k = 0; k < ex_dly; k++) begin
      rs1Data = $urandom; imm = $urandom; jump_type = 2'($urandom);
      @(negedge clk);
    end
    exec_done = 1'b1; jump_type = jt; branch_taken = bt; rs1Data = rs1v; imm = immv;
    @(negedge clk);
    exec_done = 1'b0; jump_type = 2'($urandom); rs1Data = $urandom; imm = $urandom;
    iv_upd = inst_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (pc !== RSTV) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, RSTV); end
    tests++; if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret: got %h expected 0", instret); end
    tests++; if (inst !== 32'd0 || inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst: got %h/%b expected 0/0", inst, inst_valid); end
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    tests++; if (trap !== 1'b0 || trap_addr !== 32'd0) begin fails++; $display("FAIL reset_trap: got %b/%h expected 0/0", trap, trap_addr); end
    @(negedge clk);
    tests++; if (req_valid !== 1'b1 || req_addr !== RSTV) begin fails++; $display("FAIL first_req: got %b/%h expected 1/%h", req_valid, req_addr, RSTV); end
  endtask

  task automatic test_sequential();
    logic [31:0] a, iw; logic ive, ivu, sok, ok; int hs, hs0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      do_instr(0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 32'h1000_0013 + k, a, iw, ive, ivu, sok, ok, hs);
      if (k == 0) hs0 = hs;
      tests++; if (!ok || a !== RSTV + 32'(4 * k)) begin fails++; $display("FAIL seq_addr%0d: got %h ok=%b expected %h", k, a, ok, RSTV + 32'(4 * k)); end
      tests++; if (iw !== 32'h1000_0013 + k || ive !== 1'b1 || ivu !== 1'b0) begin fails++; $display("FAIL seq_inst%0d: got %h iv=%b/%b expected %h iv=1/0", k, iw, ive, ivu, 32'h1000_0013 + k); end
    end
    tests++; if (instret !== 32'd3 || cyc - hs0 !== 12) begin fails++; $display("FAIL seq_timing: got instret %0d after %0d cycles expected 3 after 12", instret, cyc - hs0); end
  endtask

  task automatic test_stall();
    logic [31:0] a, iw; logic ive, ivu, sok, ok; int hs;
    do_reset();
    do_instr(5, 0, 0, 1, 2'd0, 1'b0, 32'd0, 32'd0, 32'hCAFE_0001, a, iw, ive, ivu, sok, ok, hs);
    tests++; if (!ok || !sok || a !== RSTV) begin fails++; $display("FAIL stall_hold: got ok=%b stable=%b addr=%h expected 1/1/%h", ok, sok, a, RSTV); end
    tests++; if (iw !== 32'hCAFE_0001) begin fails++; $display("FAIL stall_ignore_resp: got %h expected cafe0001", iw); end
    tests++; if (pc !== RSTV + 32'd4 || instret !== 32'd1) begin fails++; $display("FAIL stall_pc: got %h/%0d expected %h/1", pc, instret, RSTV + 32'd4); end
  endtask

  task automatic test_jumps_and_wrap();
    logic [1:0]  jt_t [10] = '{0, 0, 0, 0, 1, 2, 3, 3, 2, 0};
    logic        bt_t [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [31:0] rs_t [10] = '{0, 0, 0, 0, 0, 32'h80001001, 0, 0, 32'hFFFFFFFC, 0};
    logic [31:0] im_t [10] = '{0, 0, 0, 0, 32'hFFFFFFF8, 0, 32'h40, 32'h100, 0, 0};
    logic [31:0] pc_t [10] = '{32'h80000004, 32'h80000008, 32'h8000000C, 32'h80000010, 32'h80000008,
                               32'h80001000, 32'h80001004, 32'h80001104, 32'hFFFFFFFC, 32'h00000000};
    logic [31:0] a, iw; logic ive, ivu, sok, ok; int hs;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_instr(k % 3, k % 2, (k + 1) % 3, 0, jt_t[k], bt_t[k], rs_t[k], im_t[k], $urandom, a, iw, ive, ivu, sok, ok, hs);
      tests++; if (!ok || pc !== pc_t[k] || instret !== 32'(k + 1)) begin fails++; $display("FAIL jump%0d: got pc %h instret %0d ok=%b expected %h %0d", k, pc, instret, ok, pc_t[k], k + 1); end
    end
    tests++; if (req_addr !== 32'h0 || req_valid !== 1'b1) begin fails++; $display("FAIL wrap_fetch: got %b/%h expected 1/00000000", req_valid, req_addr); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a, iw; logic ive, ivu, sok, ok; int hs;
    do_reset();
    do_instr(0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 32'h11, a, iw, ive, ivu, sok, ok, hs);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; resp_valid = 1'b1; resp_inst = 32'hDEAD_BEEF;
    @(negedge clk);
    resp_valid = 1'b0;
    tests++; if (pc !== RSTV || instret !== 32'd0 || inst_valid !== 1'b0 || inst !== 32'd0) begin fails++; $display("FAIL midflight_reset: got pc %h instret %0d iv %b inst %h expected %h 0 0 0", pc, instret, inst_valid, inst, RSTV); end
    do_instr(0, 1, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 32'h2222, a, iw, ive, ivu, sok, ok, hs);
    tests++; if (!ok || a !== RSTV || iw !== 32'h2222 || pc !== RSTV + 32'd4) begin fails++; $display("FAIL midflight_resume: got addr %h inst %h pc %h expected %h 00002222 %h", a, iw, pc, RSTV, RSTV + 32'd4); end
  endtask

  task automatic test_misalign();
    logic [31:0] a, iw; logic ive, ivu, sok, ok; int hs;
    do_reset();
    do_instr(0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 32'h13, a, iw, ive, ivu, sok, ok, hs);
    do_instr(0, 0, 0, 0, 2'd1, 1'b0, 32'd0, 32'd2, 32'h6F, a, iw, ive, ivu, sok, ok, hs);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    begin
      int bad = 0;
      tests++; if (trap !== 1'b1 || trap_addr !== 32'h80000006) begin fails++; $display("FAIL trap_raise: got %b/%h expected 1/80000006", trap, trap_addr); end
      tests++; if (pc !== 32'h80000004 || instret !== 32'd1) begin fails++; $display("FAIL trap_pc: got %h/%0d expected 80000004/1", pc, instret); end
      for (int k = 0; k < 5; k++) begin
        req_ready = 1'b1;
        if (req_valid !== 1'b0 || trap !== 1'b1) bad++;
        @(negedge clk);
      end
      req_ready = 1'b0;
      tests++; if (bad != 0) begin fails++; $display("FAIL trap_hold: got %0d bad cycles expected 0", bad); end
      do_reset();
      tests++; if (trap !== 1'b0 || trap_addr !== 32'd0) begin fails++; $display("FAIL trap_clear: got %b/%h expected 0/0", trap, trap_addr); end
    end
`else
    tests++; if (!ok || pc !== 32'h80000004 || instret !== 32'd2 || trap !== 1'b0) begin fails++; $display("FAIL misalign_mask: got pc %h instret %0d trap %b expected 80000004 2 0", pc, instret, trap); end
    do_instr(0, 0, 0, 0, 2'd0, 1'b0, 32'd0, 32'd0, 32'h13, a, iw, ive, ivu, sok, ok, hs);
    tests++; if (!ok || a !== 32'h80000004 || pc !== 32'h80000008) begin fails++; $display("FAIL misalign_continue: got addr %h pc %h expected 80000004 80000008", a, pc); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a, iw, word, rv, iv, mpc, mcnt; logic [1:0] jt; logic bt;
    logic ive, ivu, sok, ok; int hs;
    do_reset();
    mpc = RSTV; mcnt = 0;
    for (int k = 0; k < 40; k++) begin
      jt = 2'($urandom); bt = 1'($urandom); rv = $urandom; iv = $urandom; word = $urandom;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      rv[1:0] = 2'b00; iv[1:0] = 2'b00;
`endif
      do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
               jt, bt, rv, iv, word, a, iw, ive, ivu, sok, ok, hs);
      tests++; if (!ok || a !== mpc || !sok) begin fails++; $display("FAIL rand_addr%0d: got %h ok=%b stable=%b expected %h", k, a, ok, sok, mpc); end
      tests++; if (iw !== word || ive !== 1'b1 || ivu !== 1'b0) begin fails++; $display("FAIL rand_inst%0d: got %h iv=%b/%b expected %h iv=1/0", k, iw, ive, ivu, word); end
      mpc = model_next(mpc, jt, bt, rv, iv);
      mcnt = mcnt + 1;
      tests++; if (pc !== mpc || instret !== mcnt) begin fails++; $display("FAIL rand_pc%0d: got %h/%0d expected %h/%0d", k, pc, instret, mpc, mcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jumps_and_wrap();
    test_reset_midflight();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
